// File: rtl/uart_alu_ctrl_pkg.sv
// Shared types and constants for the UART-to-ALU sequencer: FSM state
// encoding and the ALU opcode values carried in the third received byte.
package uart_alu_ctrl_pkg;

    typedef enum logic [2:0] {
        GET_A   = 3'd0,
        GET_B   = 3'd1,
        GET_OP  = 3'd2,
        CALC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_NOR = 6'h27;
    localparam logic [5:0] OP_SRA = 6'h03;
    localparam logic [5:0] OP_SRL = 6'h02;

endpackage

// File: rtl/uart_alu_ctrl.sv
// Collects operand A, operand B and opcode bytes from a UART receiver,
// captures the external ALU result and hands it to the UART transmitter.
module uart_alu_ctrl
    import uart_alu_ctrl_pkg::*;
#(
    parameter int DBIT  = 8,
    parameter int NB_OP = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_done_tick,
    input  logic [DBIT-1:0]  rx_data,
    input  logic [DBIT-1:0]  alu_result,
    input  logic             tx_done_tick,
    output logic [DBIT-1:0]  alu_a,
    output logic [DBIT-1:0]  alu_b,
    output logic [NB_OP-1:0] alu_op,
    output logic             tx_start,
    output logic [DBIT-1:0]  tx_data,
    output logic             busy,
    output logic             overrun
);

    state_t state_q, state_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= GET_A;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            tx_data <= '0;
        end else begin
            state_q <= state_d;
            if (rx_done_tick) begin
                case (state_q)
                    GET_A:   alu_a  <= rx_data;
                    GET_B:   alu_b  <= rx_data;
                    GET_OP:  alu_op <= NB_OP'(rx_data); // upper bits discarded
                    default: ;
                endcase
            end
            if (state_q == CALC) begin
                tx_data <= alu_result;
            end
        end
    end

    // NOTE: next state defaults to the current state before the case so no
    // path leaves state_d unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            GET_A:   if (rx_done_tick) state_d = GET_B;
            GET_B:   if (rx_done_tick) state_d = GET_OP;
            GET_OP:  if (rx_done_tick) state_d = CALC;
            CALC:    state_d = SEND;
            SEND:    state_d = WAIT_TX;
            WAIT_TX: if (tx_done_tick) state_d = GET_A;
            default: state_d = GET_A;
        endcase
    end

    // Status decodes straight from the state register; an incoming byte while
    // busy is dropped and flagged in the same cycle.
    assign tx_start = (state_q == SEND);
    assign busy     = (state_q == CALC) || (state_q == SEND) || (state_q == WAIT_TX);
    assign overrun  = rx_done_tick && busy;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Self-checking bench for uart_alu_ctrl: a behavioural ALU feeds alu_result,
// expected result bytes are queued per transaction and popped on tx_start.
module tb_uart_alu_ctrl;
    import uart_alu_ctrl_pkg::*;

    localparam int DBIT  = 8;
    localparam int NB_OP = 6;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             rx_done_tick = 1'b0;
    logic [DBIT-1:0]  rx_data = '0;
    logic [DBIT-1:0]  alu_result;
    logic             tx_done_tick = 1'b0;
    logic [DBIT-1:0]  alu_a;
    logic [DBIT-1:0]  alu_b;
    logic [NB_OP-1:0] alu_op;
    logic             tx_start;
    logic [DBIT-1:0]  tx_data;
    logic             busy;
    logic             overrun;

    int n_cmp = 0;
    int n_err = 0;
    logic [DBIT-1:0] sb_q[$];

    uart_alu_ctrl #(.DBIT(DBIT), .NB_OP(NB_OP)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .alu_result   (alu_result),
        .tx_done_tick (tx_done_tick),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [DBIT-1:0] alu_model(input logic [DBIT-1:0] a,
                                                  input logic [DBIT-1:0] b,
                                                  input logic [NB_OP-1:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SRL:  return a >> b[2:0];
            OP_SRA:  return $signed(a) >>> b[2:0];
            default: return 8'hA5;
        endcase
    endfunction

    assign alu_result = alu_model(alu_a, alu_b, alu_op);

    // Scoreboard: every transmit request must carry the oldest queued result.
    always @(negedge clk) begin
        if (!reset && tx_start) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_tx: tx_data=%h but nothing expected", tx_data);
            end else begin
                logic [DBIT-1:0] exp_b;
                exp_b = sb_q.pop_front();
                if (tx_data !== exp_b) begin
                    n_err++;
                    $display("FAIL sb_tx_data: got %h expected %h", tx_data, exp_b);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [DBIT-1:0] b);
        @(negedge clk);
        rx_data      = b;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
    endtask

    task automatic pulse_tx_done();
        @(negedge clk);
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
    endtask

    task automatic wait_tx_start(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (tx_start) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s_tx_start_timeout: tx_start=0 expected a pulse within 20 cycles", name);
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({alu_a, alu_b, alu_op, tx_data, tx_start, busy, overrun} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: a=%h b=%h op=%h txd=%h st=%b busy=%b ovr=%b expected all 0",
                     alu_a, alu_b, alu_op, tx_data, tx_start, busy, overrun);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        sb_q.push_back(8'h08);
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);               // now one cycle after the opcode tick
        n_cmp++;
        if (alu_a !== 8'h05 || alu_b !== 8'h03 || alu_op !== 6'h20) begin
            n_err++;
            $display("FAIL basic_operands: a=%h b=%h op=%h expected 05 03 20", alu_a, alu_b, alu_op);
        end
        n_cmp++;
        if (tx_start !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL basic_calc_cycle: tx_start=%b busy=%b expected 0 1", tx_start, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (tx_start !== 1'b1) begin
            n_err++;
            $display("FAIL basic_latency: tx_start=%b expected 1 two cycles after opcode", tx_start);
        end
        @(negedge clk);
        n_cmp++;
        if (tx_start !== 1'b0 || busy !== 1'b1 || tx_data !== 8'h08) begin
            n_err++;
            $display("FAIL basic_wait_tx: tx_start=%b busy=%b tx_data=%h expected 0 1 08",
                     tx_start, busy, tx_data);
        end
    endtask

    task automatic test_overrun();
        @(negedge clk);
        rx_data      = 8'hAA;
        rx_done_tick = 1'b1;
        #1;
        n_cmp++;
        if (overrun !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_pulse: overrun=%b busy=%b expected 1 1", overrun, busy);
        end
        @(negedge clk);
        rx_done_tick = 1'b0;
        #1;
        n_cmp++;
        if (overrun !== 1'b0 || busy !== 1'b1 || alu_a !== 8'h05 || alu_b !== 8'h03) begin
            n_err++;
            $display("FAIL overrun_after: overrun=%b busy=%b a=%h b=%h expected 0 1 05 03",
                     overrun, busy, alu_a, alu_b);
        end
    endtask

    task automatic test_back_to_back();
        pulse_tx_done();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle: busy=%b expected 0 after tx_done_tick", busy);
        end
        sb_q.push_back(8'h09);
        send_byte(8'h0A);
        send_byte(8'h01);
        send_byte(8'h22);
        wait_tx_start("b2b");
        @(negedge clk);
        n_cmp++;
        if (tx_data !== 8'h09) begin
            n_err++;
            $display("FAIL b2b_tx_data: tx_data=%h expected 09", tx_data);
        end
    endtask

    task automatic test_op_mask();
        pulse_tx_done();
        sb_q.push_back(8'hA5);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'hFF);
        n_cmp++;
        if (alu_op !== 6'h3F || alu_a !== 8'h01 || alu_b !== 8'h02) begin
            n_err++;
            $display("FAIL op_mask: op=%h a=%h b=%h expected 3f 01 02", alu_op, alu_a, alu_b);
        end
        wait_tx_start("op_mask");
    endtask

    task automatic test_reset_mid();
        pulse_tx_done();
        send_byte(8'h11);
        n_cmp++;
        if (alu_a !== 8'h11) begin
            n_err++;
            $display("FAIL rst_mid_a: a=%h expected 11", alu_a);
        end
        @(negedge clk);
        #2 reset = 1'b1;                 // asserted between edges
        #1;
        n_cmp++;
        if ({alu_a, alu_b, alu_op, tx_data, tx_start, busy, overrun} !== '0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: a=%h b=%h op=%h txd=%h st=%b busy=%b ovr=%b expected all 0",
                     alu_a, alu_b, alu_op, tx_data, tx_start, busy, overrun);
        end
        @(negedge clk);
        reset = 1'b0;
        sb_q.push_back(8'h55);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h20);
        n_cmp++;
        if (alu_a !== 8'h22 || alu_b !== 8'h33 || alu_op !== 6'h20) begin
            n_err++;
            $display("FAIL rst_mid_operands: a=%h b=%h op=%h expected 22 33 20", alu_a, alu_b, alu_op);
        end
        wait_tx_start("rst_mid");
    endtask

    task automatic test_rx_tx_same_cycle();
        @(negedge clk);                  // FSM is in WAIT_TX here
        rx_data      = 8'h77;
        rx_done_tick = 1'b1;
        tx_done_tick = 1'b1;
        #1;
        n_cmp++;
        if (overrun !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL same_cycle_overrun: overrun=%b busy=%b expected 1 1", overrun, busy);
        end
        @(negedge clk);
        rx_done_tick = 1'b0;
        tx_done_tick = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || overrun !== 1'b0 || alu_a !== 8'h22) begin
            n_err++;
            $display("FAIL same_cycle_state: busy=%b ovr=%b a=%h expected 0 0 22", busy, overrun, alu_a);
        end
        send_byte(8'h44);
        n_cmp++;
        if (alu_a !== 8'h44) begin
            n_err++;
            $display("FAIL same_cycle_next_a: a=%h expected 44", alu_a);
        end
        pulse_tx_done();                 // outside WAIT_TX: must be ignored
        send_byte(8'h66);
        n_cmp++;
        if (alu_b !== 8'h66 || alu_a !== 8'h44 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL tx_done_ignored: a=%h b=%h busy=%b expected 44 66 0", alu_a, alu_b, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_back_to_back();
        test_op_mask();
        test_reset_mid();
        test_rx_tx_same_cycle();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: %0d results never transmitted, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
